// File: rtl/cpc_boot_pkg.sv
// rtl/cpc_boot_pkg.sv - shared types and constants for the host boot-data feeder
// Purpose: FSM state encoding and word/checksum geometry used by the feeder
//          top module and its byte packer.
// Ports:   none (package).
package cpc_boot_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int CHECKSUM_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_REQ    = 3'd2,
    ST_ACK_LO = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/bootdata_packer.sv
// rtl/bootdata_packer.sv - packs a byte stream little-endian into 32-bit words
// Purpose: byte index counter plus the 32-bit insert register; byte 0 of each
//          word lands in word[7:0].
// Ports:
//   clk, rst   core clock, asynchronous active-high reset
//   clr        synchronous clear of index and word (new load)
//   byte_in    byte to insert
//   byte_we    insert byte_in at the current index this cycle
//   word       packed word (held until bytes of the next word overwrite it)
//   word_full  the byte written this cycle completes the word
module bootdata_packer
  import cpc_boot_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_we,
  output logic [31:0] word,
  output logic        word_full
);

  logic [IDX_W-1:0] idx;

  assign word_full = byte_we && (idx == IDX_W'(BYTES_PER_WORD - 1));

  // The index wraps naturally from 3 back to 0, so no explicit reset
  // after a full word is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx  <= '0;
      word <= '0;
    end else if (byte_we) begin
      word[{idx, 3'b000} +: 8] <= byte_in;
      idx                      <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/host_bootdata_feeder.sv
// rtl/host_bootdata_feeder.sv - host-side initiator of the ROM boot-data handshake
// Purpose: takes the MCU byte stream, packs it into 32-bit words and offers each
//          word to memory with a 4-phase req/ack handshake; flags completion
//          after ROM_BYTES bytes.
// Optional feature macro: BOOTDATA_CHECKSUM_EN adds a 16-bit byte-sum output.
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   start               pulse: clear counters and begin (or restart) a load
//   byte_in/byte_valid  stream byte and its valid
//   byte_ready          feeder accepts a byte this cycle
//   host_bootdata       packed word offered to memory
//   host_bootdata_req   word offer (level)
//   host_bootdata_ack   memory acknowledge (level)
//   load_busy           load in progress
//   load_done           image delivered; sticky until start or rst
//   checksum            modulo-2^16 sum of accepted bytes (macro builds only)
module host_bootdata_feeder
  import cpc_boot_pkg::*;
#(
  parameter int ROM_BYTES = 49152,
  parameter int CNT_W     = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [31:0] host_bootdata,
  output logic        host_bootdata_req,
  input  logic        host_bootdata_ack,
  output logic        load_busy,
  output logic        load_done
`ifdef BOOTDATA_CHECKSUM_EN
  ,
  output logic [CHECKSUM_W-1:0] checksum
`endif
);

  localparam logic [CNT_W-1:0] WORDS = CNT_W'(ROM_BYTES / BYTES_PER_WORD);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] word_cnt;
  logic             accept;
  logic             word_full;

  // A start in the same cycle as a byte handshake discards that byte.
  assign accept = byte_valid && (state == ST_FILL) && !start;

  bootdata_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (start),
    .byte_in   (byte_in),
    .byte_we   (accept),
    .word      (host_bootdata),
    .word_full (word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // An abort while a handshake may be open parks in ACK_LO so a new req
  // is only raised after ack has been seen low.
  always_comb begin
    state_nxt         = state;
    byte_ready        = 1'b0;
    host_bootdata_req = 1'b0;
    load_busy         = 1'b0;
    load_done         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_FILL;
      end
      ST_FILL: begin
        byte_ready = 1'b1;
        load_busy  = 1'b1;
        if (start)                      state_nxt = ST_ACK_LO;
        else if (accept && word_full)   state_nxt = ST_REQ;
      end
      ST_REQ: begin
        host_bootdata_req = 1'b1;
        load_busy         = 1'b1;
        if (start || host_bootdata_ack) state_nxt = ST_ACK_LO;
      end
      ST_ACK_LO: begin
        load_busy = 1'b1;
        if (!start && !host_bootdata_ack)
          state_nxt = (word_cnt == WORDS) ? ST_DONE : ST_FILL;
      end
      ST_DONE: begin
        load_done = 1'b1;
        if (start) state_nxt = ST_FILL;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Start wins over a simultaneous ack, so that ack is never counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (start) begin
      word_cnt <= '0;
    end else if (state == ST_REQ && host_bootdata_ack && word_cnt != WORDS) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end

`ifdef BOOTDATA_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (start) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + {{(CHECKSUM_W - 8){1'b0}}, byte_in};
    end
  end
`endif

endmodule

// File: tb/tb_host_bootdata_feeder.sv
// tb/tb_host_bootdata_feeder.sv - self-checking bench for host_bootdata_feeder
module tb_host_bootdata_feeder;

  localparam int ROM_BYTES = 16;
  localparam int WORDS     = ROM_BYTES / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] host_bootdata;
  logic        req;
  logic        ack;
  logic        load_busy;
  logic        load_done;
`ifdef BOOTDATA_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int checks = 0;
  int errors = 0;
  int words_done = 0;
  int sum_model  = 0;

  always #5 clk = ~clk;

  host_bootdata_feeder #(.ROM_BYTES(ROM_BYTES), .CNT_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .byte_in           (byte_in),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .host_bootdata     (host_bootdata),
    .host_bootdata_req (req),
    .host_bootdata_ack (ack),
    .load_busy         (load_busy),
    .load_done         (load_done)
`ifdef BOOTDATA_CHECKSUM_EN
    ,
    .checksum          (checksum)
`endif
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_byte_timeout: byte_ready=%b required 1", byte_ready);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    sum_model  = (sum_model + int'(b)) % 65536;
  endtask

  task automatic begin_load;
    int n = 0;
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    words_done = 0;
    sum_model  = 0;
    while (byte_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL begin_load: byte_ready=%b required 1", byte_ready);
    end
  endtask

  task automatic do_word(input logic [31:0] w, input int ack_dly, input bit glitch);
    for (int i = 0; i < 4; i++) begin
      if (glitch && i == 2) begin
        ack = 1'b1;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b1 || req !== 1'b0) begin
          errors++;
          $display("FAIL ack_in_fill: ready=%b req=%b required ready=1 req=0", byte_ready, req);
        end
        ack = 1'b0;
      end
      push_byte(w[8*i +: 8]);
    end
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL req_rise: req=%b required 1", req);
    end
    checks++;
    if (host_bootdata !== w) begin
      errors++;
      $display("FAIL word: got %h required %h", host_bootdata, w);
    end
    for (int k = 0; k < ack_dly; k++) begin
      @(negedge clk);
      checks++;
      if (req !== 1'b1 || host_bootdata !== w) begin
        errors++;
        $display("FAIL req_hold: req=%b word=%h required req=1 word=%h", req, host_bootdata, w);
      end
    end
    ack = 1'b1;
    @(negedge clk);
    if (words_done < WORDS) words_done++;
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL req_fall: req=%b required 0", req);
    end
    ack = 1'b0;
    @(negedge clk);
    checks++;
    if (load_done !== 1'(words_done == WORDS)) begin
      errors++;
      $display("FAIL done_flag: load_done=%b required %b after %0d words",
               load_done, words_done == WORDS, words_done);
    end
    checks++;
    if (byte_ready !== 1'(words_done != WORDS)) begin
      errors++;
      $display("FAIL ready_after_word: byte_ready=%b required %b", byte_ready, words_done != WORDS);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; ack = 1'b0; byte_in = 8'h00;
    repeat (2) @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || req !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b req=%b busy=%b done=%b required all 0",
               byte_ready, req, load_busy, load_done);
    end
    checks++;
    if (host_bootdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_word: got %h required 00000000", host_bootdata);
    end
`ifdef BOOTDATA_CHECKSUM_EN
    checks++;
    if (checksum !== 16'h0) begin
      errors++;
      $display("FAIL reset_checksum: got %h required 0000", checksum);
    end
`endif
    rst = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_ignored: ready=%b busy=%b required 0 0", byte_ready, load_busy);
    end
    ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word;
    begin_load();
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL t1_req_early: req=%b required 0 before byte 4", req);
    end
    push_byte(8'h04);
    checks++;
    if (req !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL t1_req_latency: req=%b ready=%b required 1 0", req, byte_ready);
    end
    checks++;
    if (host_bootdata !== 32'h04030201) begin
      errors++;
      $display("FAIL t1_word: got %h required 04030201", host_bootdata);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (req !== 1'b1) begin
        errors++;
        $display("FAIL t1_req_hold: req=%b required 1", req);
      end
    end
    ack = 1'b1;
    @(negedge clk);
    checks++;
    if (req !== 1'b0) begin
      errors++;
      $display("FAIL t1_req_fall: req=%b required 0", req);
    end
    ack = 1'b0;
    @(negedge clk);
    words_done = 1;
    checks++;
    if (byte_ready !== 1'b1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL t1_refill: ready=%b done=%b required 1 0", byte_ready, load_done);
    end
    for (int i = 1; i < WORDS; i++) do_word($urandom, $urandom_range(0, 3), 1'b0);
  endtask

  task automatic test_full_load;
    begin_load();
    for (int i = 0; i < WORDS; i++) do_word($urandom, $urandom_range(0, 3), 1'b0);
    checks++;
    if (load_done !== 1'b1 || load_busy !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL t2_done_state: done=%b busy=%b ready=%b required 1 0 0",
               load_done, load_busy, byte_ready);
    end
    byte_valid = 1'b1;
    byte_in    = 8'($urandom);
    ack        = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || load_done !== 1'b1) begin
        errors++;
        $display("FAIL t2_done_sticky: ready=%b done=%b required 0 1", byte_ready, load_done);
      end
    end
    byte_valid = 1'b0;
    ack        = 1'b0;
`ifdef BOOTDATA_CHECKSUM_EN
    checks++;
    if (checksum !== 16'(sum_model)) begin
      errors++;
      $display("FAIL t2_checksum: got %h required %h", checksum, 16'(sum_model));
    end
`endif
  endtask

  task automatic test_ack_held;
    logic [31:0] w;
    begin_load();
    w = $urandom;
    for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8]);
    checks++;
    if (req !== 1'b1 || host_bootdata !== w) begin
      errors++;
      $display("FAIL t3_offer: req=%b word=%h required 1 %h", req, host_bootdata, w);
    end
    byte_valid = 1'b1;
    byte_in    = 8'($urandom);
    ack        = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (req !== 1'b0 || byte_ready !== 1'b0) begin
        errors++;
        $display("FAIL t3_ack_held: req=%b ready=%b required 0 0", req, byte_ready);
      end
    end
    ack        = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    words_done = 1;
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL t3_refill: byte_ready=%b required 1", byte_ready);
    end
    for (int i = 1; i < WORDS; i++) do_word($urandom, $urandom_range(0, 2), 1'b0);
  endtask

  task automatic test_abort;
    logic [31:0] w;
    begin_load();
    do_word($urandom, 1, 1'b0);
    do_word($urandom, 0, 1'b0);
    w = $urandom;
    for (int i = 0; i < 4; i++) push_byte(w[8*i +: 8]);
    start = 1'b1;
    ack   = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    words_done = 0;
    sum_model  = 0;
    checks++;
    if (req !== 1'b0 || load_busy !== 1'b1 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL t4_abort: req=%b busy=%b ready=%b required 0 1 0", req, load_busy, byte_ready);
    end
`ifdef BOOTDATA_CHECKSUM_EN
    checks++;
    if (checksum !== 16'h0) begin
      errors++;
      $display("FAIL t4_checksum_clear: got %h required 0000", checksum);
    end
`endif
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL t4_wait_ack_low: byte_ready=%b required 0", byte_ready);
    end
    ack = 1'b0;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL t4_refill: byte_ready=%b required 1", byte_ready);
    end
    do_word(32'h04030201, 1, 1'b0);
    do_word($urandom, 2, 1'b1);
    for (int i = 2; i < WORDS; i++) do_word($urandom, 0, 1'b0);
`ifdef BOOTDATA_CHECKSUM_EN
    checks++;
    if (checksum !== 16'(sum_model)) begin
      errors++;
      $display("FAIL t4_checksum: got %h required %h", checksum, 16'(sum_model));
    end
`endif
  endtask

  task automatic test_async_reset;
    begin_load();
    for (int i = 0; i < 4; i++) push_byte(8'($urandom));
    checks++;
    if (req !== 1'b1) begin
      errors++;
      $display("FAIL t5_req: req=%b required 1", req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (req !== 1'b0 || byte_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL t5_async_ctrl: req=%b ready=%b busy=%b done=%b required all 0",
               req, byte_ready, load_busy, load_done);
    end
    checks++;
    if (host_bootdata !== 32'h0) begin
      errors++;
      $display("FAIL t5_async_word: got %h required 00000000", host_bootdata);
    end
`ifdef BOOTDATA_CHECKSUM_EN
    checks++;
    if (checksum !== 16'h0) begin
      errors++;
      $display("FAIL t5_async_checksum: got %h required 0000", checksum);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || load_busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_idle_after: ready=%b busy=%b required 0 0", byte_ready, load_busy);
    end
  endtask

`ifdef BOOTDATA_CHECKSUM_EN
  task automatic test_checksum;
    begin_load();
    for (int i = 0; i < 4; i++) push_byte(8'hFF);
    checks++;
    if (checksum !== 16'h03FC) begin
      errors++;
      $display("FAIL t6_checksum: got %h required 03fc", checksum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_full_load();
    test_ack_held();
    test_abort();
    test_async_reset();
`ifdef BOOTDATA_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
